fechadura_ctrl_param: RTL
=========================

Name: fechadura_ctrl_param

Overview:
Parametrised successor of the electronic-lock operational controller. It has N_USERS user password slots plus one master slot, each MAX_DIGITS digits long. The active configuration is held in registers and updated only on a commit handshake. All timing runs from a seconds prescaler. Lockout time doubles on each consecutive lockout. Sits between the keypad/digit-collector block and the lock actuator, buzzer and display drivers.

Parameters:
N_USERS, 4, number of user password slots (slot 0 = master, slots 1..N_USERS = users)
MAX_DIGITS, 20, digits per password, 4 bits each; unused trailing digits = 4'hF
TICKS_PER_SEC, 1000, clk cycles per one-second tick
DB_CYCLES, 100, button debounce: cycles held before accepted
HOLD_CYCLES, 3000, botao_bloqueio hold to enter do-not-disturb
MAX_TENT, 5, failed attempts before lockout
LOCK_SEC, 30, base lockout seconds
LOCK_MAX_SHIFT, 3, cap on lockout doubling (max LOCK_SEC<<3)
DEF_BIP_S, 5, reset bip_time; DEF_TRANCA_S, 5, reset auto-lock time
DEF_MASTER, {4'h1,4'h2,4'h3,4'h4, rest 4'hF}, reset master password

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
sensor_contato  in  1  1 = door physically open
botao_interno  in  1  inside unlock button, level
botao_bloqueio  in  1  do-not-disturb button, level
botao_config  in  1  setup request button, level
cfg_bip_status  in  1  new buzzer enable
cfg_bip_time  in  6  new seconds door may stay open before buzzer
cfg_tranca_time  in  6  new auto-relock seconds
cfg_senhas  in  (N_USERS+1)*MAX_DIGITS*4  new passwords, slot 0 in LSBs
data_setup_ok  in  1  1-cycle commit of cfg_* into active config
digitos_value  in  MAX_DIGITS*4  entered code, digit 0 in LSBs
digitos_valid  in  1  1-cycle strobe qualifying digitos_value
tranca  out  1  1 = bolt engaged
bip  out  1  buzzer
teclado_en  out  1  keypad accepting entry
display_en  out  1  display enable
setup_on  out  1  setup mode active
bloqueado  out  1  lockout active
tentativas  out  $clog2(MAX_TENT+1)  failed-attempt count

Behaviour:
- Reset: state INIT; all counters = 0; lock_shift = 0; active config = {1, DEF_BIP_S, DEF_TRANCA_S, DEF_MASTER, user slots all 4'hF}.
- Reset output values: tranca=1, bip=0, teclado_en=0, display_en=0, setup_on=0, bloqueado=0, tentativas=0.
- Outputs are decoded from registered state (Moore). tranca=0 only in DESTRAVADA, ABERTA, BIP, DB_CFG, SETUP. teclado_en=1 in TRANCADA, NAO_PERTURBE. display_en = teclado_en | bloqueado | setup_on. bip = (state==BIP) & cfg_bip_status.
- Seconds prescaler: cleared on every state change; emits a 1-cycle tick every TICKS_PER_SEC cycles. sec_cnt is cleared on state change and incremented on tick.
- A slot is enabled iff digit 0 != 4'hF. Match = all MAX_DIGITS digits equal.
- Entry is ignored (no state change, no attempt counted) if digit0 is 4'hE (keypad timeout), 4'hB or 4'hF.
- INIT: !sensor_contato -> TRANCADA.
- TRANCADA:
  - botao_bloqueio -> DB_BLQ (highest priority).
  - else botao_interno -> DB_INT.
  - else a valid entry -> VALIDAR (digitos_value registered).
- DB_BLQ: botao_bloqueio released -> TRANCADA; held count reaches HOLD_CYCLES -> NAO_PERTURBE.
- NAO_PERTURBE: botao_interno -> DB_INT. A valid entry is compared to the master slot only: match -> DESTRAVADA, mismatch counts as an attempt.
- DB_INT: released before DB_CYCLES -> return to the originating state; held DB_CYCLES -> DESTRAVADA.
- VALIDAR (1 cycle): any enabled slot matches -> DESTRAVADA and tentativas=0. Else tentativas+1; if the new value == MAX_TENT -> BLOQUEADO, else back to the originating state.
- BLOQUEADO: tentativas=0 on entry. Exit to TRANCADA when sec_cnt == LOCK_SEC<<lock_shift; on exit lock_shift increments, saturating at LOCK_MAX_SHIFT. lock_shift clears on any successful unlock. Buttons and entries are ignored.
- DESTRAVADA: sensor_contato -> ABERTA; sec_cnt == cfg_tranca_time -> TRANCADA; botao_interno (debounced) -> TRANCADA. sensor_contato wins on a same-cycle tie.
- ABERTA: sec_cnt == cfg_bip_time -> BIP; !sensor_contato -> DESTRAVADA (new relock window); botao_config -> DB_CFG.
- BIP: !sensor_contato -> DESTRAVADA; botao_config -> DB_CFG, which wins over door close.
- DB_CFG: released early -> originating state; held DB_CYCLES -> SETUP.
- SETUP: on data_setup_ok, cfg_* is latched into the active config and the FSM goes to ABERTA. The new values apply from the next cycle.
- A time value of 0 means expiry on the first cycle after entry.
- Reset mid-operation returns everything to reset values, including the active config.

Test Plan:
- Parameters for all tests: TICKS_PER_SEC=10, DB_CYCLES=4, HOLD_CYCLES=20, MAX_TENT=3, LOCK_SEC=2.
- Correct master entry: close door, pulse digitos_valid with 1234FFFF… -> tranca=0 two cycles later; tentativas=0.
- Lockout escalation: 3 wrong codes -> bloqueado=1 for exactly 20 cycles, tentativas=0. 3 more wrong codes -> bloqueado held for 40 cycles.
- Ignored entries: digit0=4'hE or 4'hF -> no state change, tentativas unchanged.
- Do-not-disturb: hold botao_bloqueio 21 cycles -> NAO_PERTURBE. A user-slot code is rejected (tentativas=1); the master code unlocks.
- Open-door buzzer: unlock, open the door, cfg_bip_time=3 -> bip=1 at cycle 30. Closing the door gives tranca=1 after cfg_tranca_time seconds.
- Setup commit: from BIP, hold botao_config 4 cycles -> setup_on=1. data_setup_ok with slot1=5555… -> ABERTA. After relock, code 5555 unlocks. rst asserted mid-SETUP restores DEF_MASTER.

Source files
------------

// File: rtl/fechadura_ctrl_param.sv
// Electronic-lock operational controller with parametrised password slots,
// seconds prescaler, debounced buttons and escalating lockout.
module fechadura_ctrl_param #(
  parameter int unsigned N_USERS        = 4,
  parameter int unsigned MAX_DIGITS     = 20,
  parameter int unsigned TICKS_PER_SEC  = 1000,
  parameter int unsigned DB_CYCLES      = 100,
  parameter int unsigned HOLD_CYCLES    = 3000,
  parameter int unsigned MAX_TENT       = 5,
  parameter int unsigned LOCK_SEC       = 30,
  parameter int unsigned LOCK_MAX_SHIFT = 3,
  parameter int unsigned DEF_BIP_S      = 5,
  parameter int unsigned DEF_TRANCA_S   = 5,
  parameter logic [MAX_DIGITS*4-1:0] DEF_MASTER = {{(MAX_DIGITS-4){4'hF}}, 16'h4321}
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 sensor_contato,
  input  logic                                 botao_interno,
  input  logic                                 botao_bloqueio,
  input  logic                                 botao_config,
  input  logic                                 cfg_bip_status,
  input  logic [5:0]                           cfg_bip_time,
  input  logic [5:0]                           cfg_tranca_time,
  input  logic [(N_USERS+1)*MAX_DIGITS*4-1:0]  cfg_senhas,
  input  logic                                 data_setup_ok,
  input  logic [MAX_DIGITS*4-1:0]              digitos_value,
  input  logic                                 digitos_valid,
  output logic                                 tranca,
  output logic                                 bip,
  output logic                                 teclado_en,
  output logic                                 display_en,
  output logic                                 setup_on,
  output logic                                 bloqueado,
  output logic [$clog2(MAX_TENT+1)-1:0]        tentativas
);

  localparam int unsigned CW = MAX_DIGITS * 4;
  localparam int unsigned NS = N_USERS + 1;
  localparam int unsigned TW = $clog2(MAX_TENT + 1);
  localparam logic [NS*CW-1:0] SENHAS_RST = {{N_USERS{{MAX_DIGITS{4'hF}}}}, DEF_MASTER};

  typedef enum logic [3:0] {
    INIT, TRANCADA, DB_BLQ, NAO_PERTURBE, DB_INT, VALIDAR,
    BLOQUEADO, DESTRAVADA, ABERTA, BIP, DB_CFG, SETUP
  } state_t;

  state_t            state, next_state, orig;
  logic [31:0]       pre_cnt, sec_cnt, db_cnt, sec_nxt, lock_target;
  logic              tick, btn_sel, entry_ok, any_match;
  logic              exp_lock, exp_tranca, exp_bip;
  logic [CW-1:0]     code_reg, slot;
  logic [TW-1:0]     tent_r, tent_inc;
  logic [7:0]        lock_shift;
  logic              bip_status_r;
  logic [5:0]        bip_time_r, tranca_time_r;
  logic [NS*CW-1:0]  senhas_r;

  assign tick        = (pre_cnt == TICKS_PER_SEC - 1);
  assign sec_nxt     = sec_cnt + 32'd1;
  assign lock_target = 32'(LOCK_SEC) << lock_shift;
  assign tent_inc    = tent_r + TW'(1);
  assign entry_ok    = digitos_valid && !(digitos_value[3:0] inside {4'hE, 4'hB, 4'hF});

  // Expiry fires on the tick that completes the target second, so a target
  // of N seconds lasts exactly N*TICKS_PER_SEC cycles and 0 expires at once.
  assign exp_lock   = (sec_cnt == lock_target) || (tick && sec_nxt == lock_target);
  assign exp_tranca = (sec_cnt == 32'(tranca_time_r)) || (tick && sec_nxt == 32'(tranca_time_r));
  assign exp_bip    = (sec_cnt == 32'(bip_time_r)) || (tick && sec_nxt == 32'(bip_time_r));

  // State register; remember where a debounce/validation detour came from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      orig  <= INIT;
    end else begin
      state <= next_state;
      if (next_state != state && next_state inside {DB_INT, VALIDAR, DB_CFG})
        orig <= state;
    end
  end

  // Button watched by the hold counter in the current state
  always_comb begin
    btn_sel = 1'b0;
    case (state)
      DB_BLQ:             btn_sel = botao_bloqueio;
      DB_INT, DESTRAVADA: btn_sel = botao_interno;
      DB_CFG:             btn_sel = botao_config;
      default:            btn_sel = 1'b0;
    endcase
  end

  // Prescaler, seconds and hold counters, all restarted on state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      sec_cnt <= '0;
      db_cnt  <= '0;
    end else if (next_state != state) begin
      pre_cnt <= '0;
      sec_cnt <= '0;
      db_cnt  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 32'd1;
      if (tick) sec_cnt <= sec_nxt;
      db_cnt  <= btn_sel ? db_cnt + 32'd1 : '0;
    end
  end

  // Entered code capture, attempt counter and lockout escalation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_reg   <= '0;
      tent_r     <= '0;
      lock_shift <= '0;
    end else begin
      if (state != VALIDAR && next_state == VALIDAR)
        code_reg <= digitos_value;
      if (state == VALIDAR)
        tent_r <= (any_match || tent_inc == TW'(MAX_TENT)) ? '0 : tent_inc;
      if (state == BLOQUEADO && next_state == TRANCADA && lock_shift != 8'(LOCK_MAX_SHIFT))
        lock_shift <= lock_shift + 8'd1;
      else if (state != DESTRAVADA && next_state == DESTRAVADA)
        lock_shift <= '0;
    end
  end

  // Active configuration, replaced only by a commit while in setup
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bip_status_r  <= 1'b1;
      bip_time_r    <= 6'(DEF_BIP_S);
      tranca_time_r <= 6'(DEF_TRANCA_S);
      senhas_r      <= SENHAS_RST;
    end else if (state == SETUP && data_setup_ok) begin
      bip_status_r  <= cfg_bip_status;
      bip_time_r    <= cfg_bip_time;
      tranca_time_r <= cfg_tranca_time;
      senhas_r      <= cfg_senhas;
    end
  end

  // Compare captured code against enabled slots; do-not-disturb allows master only
  always_comb begin
    any_match = 1'b0;
    slot      = '0;
    for (int unsigned s = 0; s < NS; s++) begin
      slot = senhas_r[s*CW +: CW];
      if (slot[3:0] != 4'hF && slot == code_reg && (s == 0 || orig != NAO_PERTURBE))
        any_match = 1'b1;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    next_state = state;
    case (state)
      INIT:         if (!sensor_contato) next_state = TRANCADA;
      TRANCADA: begin
        if (botao_bloqueio)     next_state = DB_BLQ;
        else if (botao_interno) next_state = DB_INT;
        else if (entry_ok)      next_state = VALIDAR;
      end
      DB_BLQ: begin
        if (!botao_bloqueio)                next_state = TRANCADA;
        else if (db_cnt == HOLD_CYCLES - 1) next_state = NAO_PERTURBE;
      end
      NAO_PERTURBE: begin
        if (botao_interno)  next_state = DB_INT;
        else if (entry_ok)  next_state = VALIDAR;
      end
      DB_INT: begin
        if (!botao_interno)               next_state = orig;
        else if (db_cnt == DB_CYCLES - 1) next_state = DESTRAVADA;
      end
      VALIDAR: begin
        if (any_match)                         next_state = DESTRAVADA;
        else if (tent_inc == TW'(MAX_TENT))    next_state = BLOQUEADO;
        else                                   next_state = orig;
      end
      BLOQUEADO:    if (exp_lock) next_state = TRANCADA;
      DESTRAVADA: begin
        if (sensor_contato)                                 next_state = ABERTA;
        else if (exp_tranca)                                next_state = TRANCADA;
        else if (botao_interno && db_cnt == DB_CYCLES - 1)  next_state = TRANCADA;
      end
      ABERTA: begin
        if (botao_config)         next_state = DB_CFG;
        else if (!sensor_contato) next_state = DESTRAVADA;
        else if (exp_bip)         next_state = BIP;
      end
      BIP: begin
        if (botao_config)         next_state = DB_CFG;
        else if (!sensor_contato) next_state = DESTRAVADA;
      end
      DB_CFG: begin
        if (!botao_config)                next_state = orig;
        else if (db_cnt == DB_CYCLES - 1) next_state = SETUP;
      end
      SETUP:        if (data_setup_ok) next_state = ABERTA;
      default:      next_state = INIT;
    endcase

    tranca     = !(state inside {DESTRAVADA, ABERTA, BIP, DB_CFG, SETUP});
    teclado_en = (state == TRANCADA) || (state == NAO_PERTURBE);
    bloqueado  = (state == BLOQUEADO);
    setup_on   = (state == SETUP);
    display_en = teclado_en || bloqueado || setup_on;
    bip        = (state == BIP) && bip_status_r;
    tentativas = tent_r;
  end

endmodule
